// File: rtl/branch_resolve_if.sv
// Branch-resolution bus: fetch-slot info in, EX outcome in, redirect/update/stats out.
interface branch_resolve_if;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_btype;
  logic        if_predict;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        upd_btype;
  logic        upd_taken;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport slave (
    input  stall, if_valid, if_pc, if_btype, if_predict, ex_taken, ex_target,
    output mispredict, redirect_pc, upd_btype, upd_taken, stat_branches, stat_mispredicts
  );

  modport master (
    output stall, if_valid, if_pc, if_btype, if_predict, ex_taken, ex_target,
    input  mispredict, redirect_pc, upd_btype, upd_taken, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_resolve.sv
// Tracks fetched instructions through ID/EX and resolves conditional branches in EX.
// Optional saturating statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve (
  input  logic             clk,
  input  logic             rst,
  branch_resolve_if.slave  bus
);

  logic        id_valid_reg;
  logic [31:0] id_pc_reg;
  logic        id_btype_reg;
  logic        id_predict_reg;

  logic        ex_valid_reg;
  logic [31:0] ex_pc_reg;
  logic        ex_btype_reg;
  logic        ex_predict_reg;

  logic        resolve;
  logic        mispredict;

  assign resolve    = ex_valid_reg & ex_btype_reg & ~bus.stall;
  assign mispredict = resolve & (ex_predict_reg != bus.ex_taken);

  assign bus.mispredict  = mispredict;
  assign bus.redirect_pc = mispredict ? (bus.ex_taken ? bus.ex_target : ex_pc_reg + 32'd4)
                                      : 32'h0;
  assign bus.upd_btype   = resolve;
  assign bus.upd_taken   = resolve & bus.ex_taken;

  // A mispredict squashes both younger instructions (the one entering ID and the one entering EX).
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_reg   <= 1'b0;
      id_pc_reg      <= 32'h0;
      id_btype_reg   <= 1'b0;
      id_predict_reg <= 1'b0;
      ex_valid_reg   <= 1'b0;
      ex_pc_reg      <= 32'h0;
      ex_btype_reg   <= 1'b0;
      ex_predict_reg <= 1'b0;
    end else if (!bus.stall) begin
      id_valid_reg   <= bus.if_valid & ~mispredict;
      id_pc_reg      <= bus.if_pc;
      id_btype_reg   <= bus.if_btype;
      id_predict_reg <= bus.if_predict;
      ex_valid_reg   <= id_valid_reg & ~mispredict;
      ex_pc_reg      <= id_pc_reg;
      ex_btype_reg   <= id_btype_reg;
      ex_predict_reg <= id_predict_reg;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [1:0] stat_inc;
  assign stat_inc = {mispredict, resolve};

  // Counter 0 counts resolved branches, counter 1 counts mispredicts; both stick at all-ones.
  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    logic [31:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= 32'h0;
      end else if (stat_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign bus.stat_branches    = g_stat[0].cnt_reg;
  assign bus.stat_mispredicts = g_stat[1].cnt_reg;
`else
  assign bus.stat_branches    = 32'h0;
  assign bus.stat_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed scoreboard bench for branch_resolve: expected resolutions are queued at fetch
// and checked when the branch reaches EX after two unstalled edges.
module tb_branch_resolve;

  logic clk;
  logic rst;

  branch_resolve_if bus ();

  branch_resolve dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pr;
    logic        tk;
    logic [31:0] tgt;
    int          age;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   br_cnt = 0;
  int   mis_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs at the falling edge, then cross the rising edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic bt, input logic pr,
                      input logic tk, input logic [31:0] tgt, input logic st);
    ent_t        e;
    logic        exp_upd;
    logic        exp_mis;
    logic [31:0] exp_red;
    bus.stall      = st;
    bus.if_valid   = v;
    bus.if_pc      = pc;
    bus.if_btype   = bt;
    bus.if_predict = pr;
    if (v && bt && !st) begin
      e.pc = pc; e.pr = pr; e.tk = tk; e.tgt = tgt; e.age = 0;
      q.push_back(e);
    end
    if (q.size() > 0) begin
      bus.ex_taken  = q[0].tk;
      bus.ex_target = q[0].tgt;
    end else begin
      bus.ex_taken  = 1'b1;
      bus.ex_target = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    exp_upd = !st && (q.size() > 0) && (q[0].age == 2);
    chk("upd_btype", {31'h0, bus.upd_btype}, {31'h0, exp_upd});
    if (exp_upd) begin
      e = q.pop_front();
      exp_mis = (e.pr != e.tk);
      exp_red = exp_mis ? (e.tk ? e.tgt : e.pc + 32'd4) : 32'h0;
      chk("mispredict", {31'h0, bus.mispredict}, {31'h0, exp_mis});
      chk("redirect_pc", bus.redirect_pc, exp_red);
      chk("upd_taken", {31'h0, bus.upd_taken}, {31'h0, e.tk});
      br_cnt++;
      if (exp_mis) begin
        mis_cnt++;
        q.delete();
      end
      $display("txn pc=%h pred=%0d taken=%0d mispredict=%0d redirect=%h",
               e.pc, e.pr, e.tk, bus.mispredict, bus.redirect_pc);
    end else begin
      chk("quiet_mispredict", {31'h0, bus.mispredict}, 32'h0);
      chk("quiet_redirect", bus.redirect_pc, 32'h0);
      chk("quiet_upd_taken", {31'h0, bus.upd_taken}, 32'h0);
    end
    @(posedge clk);
    if (!st) foreach (q[i]) q[i].age++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Reset cycle with a branch offered at IF and stall forced high; EX is empty here.
  task automatic do_reset();
    rst            = 1'b1;
    bus.stall      = 1'b1;
    bus.if_valid   = 1'b1;
    bus.if_pc      = 32'h0000_0504;
    bus.if_btype   = 1'b1;
    bus.if_predict = 1'b0;
    bus.ex_taken   = 1'b1;
    bus.ex_target  = 32'h0000_0900;
    @(negedge clk);
    chk("rst_upd_btype", {31'h0, bus.upd_btype}, 32'h0);
    chk("rst_mispredict", {31'h0, bus.mispredict}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    br_cnt  = 0;
    mis_cnt = 0;
  endtask

  task automatic chk_stats(input string tag, input int exp_br, input int exp_mis);
`ifdef BRANCH_STATS_EN
    chk({tag, "_branches"}, bus.stat_branches, 32'(exp_br));
    chk({tag, "_mispredicts"}, bus.stat_mispredicts, 32'(exp_mis));
`else
    chk({tag, "_branches"}, bus.stat_branches, 32'h0);
    chk({tag, "_mispredicts"}, bus.stat_mispredicts, 32'h0);
    if (exp_br < 0 || exp_mis < 0) $display("note: negative expectation");
`endif
  endtask

  initial begin
    rst            = 1'b1;
    bus.stall      = 1'b0;
    bus.if_valid   = 1'b0;
    bus.if_pc      = 32'h0;
    bus.if_btype   = 1'b0;
    bus.if_predict = 1'b0;
    bus.ex_taken   = 1'b0;
    bus.ex_target  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    idle(1);
    chk_stats("reset", 0, 0);

    // Correct prediction, taken
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 32'h0000_0140, 1'b0);
    idle(2);

    // Predicted not-taken, actually taken; the two following branches are squashed
    step(1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 32'h0000_0180, 1'b0);
    step(1'b1, 32'h0000_0204, 1'b1, 1'b0, 1'b1, 32'h0000_0999, 1'b0);
    step(1'b1, 32'h0000_0208, 1'b1, 1'b0, 1'b1, 32'h0000_0999, 1'b0);
    step(1'b1, 32'h0000_020C, 1'b1, 1'b1, 1'b1, 32'h0000_0280, 1'b0);
    idle(2);

    // Predicted taken, actually not taken
    step(1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b0, 32'h0000_0380, 1'b0);
    idle(2);

    // Non-branch instructions never resolve
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h0000_0600 + 32'(4 * i), 1'b0, 1'b0, 1'b1, 32'h0000_0700, 1'b0);
    idle(2);

    // Stall with a mispredicting branch held in EX for three cycles
    step(1'b1, 32'h0000_0400, 1'b1, 1'b1, 1'b0, 32'h0000_0480, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h0000_0404, 1'b1, 1'b0, 1'b1, 32'h0000_0111, 1'b1);
    idle(3);

    // PC wrap on not-taken redirect
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 1'b0);
    idle(2);
    chk("queue_drained", 32'(q.size()), 32'h0);
    chk_stats("run", br_cnt, mis_cnt);

    // Reset mid-flight: a mispredicting branch sits in ID when reset hits
    step(1'b1, 32'h0000_0500, 1'b1, 1'b0, 1'b1, 32'h0000_0600, 1'b0);
    do_reset();
    idle(3);
    chk_stats("midrst", 0, 0);

    // Five branches, two mispredicts
    step(1'b1, 32'h0000_0700, 1'b1, 1'b1, 1'b1, 32'h0000_0780, 1'b0); idle(2);
    step(1'b1, 32'h0000_0710, 1'b1, 1'b0, 1'b1, 32'h0000_0800, 1'b0); idle(2);
    step(1'b1, 32'h0000_0720, 1'b1, 1'b0, 1'b0, 32'h0000_0820, 1'b0); idle(2);
    step(1'b1, 32'h0000_0730, 1'b1, 1'b1, 1'b0, 32'h0000_0840, 1'b0); idle(2);
    step(1'b1, 32'h0000_0740, 1'b1, 1'b1, 1'b1, 32'h0000_0860, 1'b0); idle(2);
    chk("queue_drained2", 32'(q.size()), 32'h0);
    chk_stats("five", 5, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
